// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus scheduler: one functional-unit result per cycle,
// registered onto the CDB with a one-cycle latency.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*W_TAG-1:0]  req_tag,
  input  logic [N_REQ*W_DATA-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [W_TAG-1:0]        cdb_tag,
  output logic [W_DATA-1:0]       cdb_data,
  output logic [N_REQ-1:0]        cdb_src_onehot
);

  localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [W_PTR-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [W_TAG-1:0]  r_cdb_tag;
  logic [W_DATA-1:0] r_cdb_data;
  logic [N_REQ-1:0]  r_cdb_src;

  logic [W_PTR-1:0]  w_win;
  logic [W_PTR-1:0]  w_ptr_nxt;
  logic [W_PTR:0]    w_idx;
  logic              w_found;
  logic              w_xfer;
  logic [N_REQ-1:0]  w_grant;
  logic [W_TAG-1:0]  w_tag;
  logic [W_DATA-1:0] w_data;

  // Walk from the pointer, wrapping; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (W_PTR+1)'(k);
      if (w_idx >= (W_PTR+1)'(N_REQ))
        w_idx = w_idx - (W_PTR+1)'(N_REQ);
      if (!w_found && req_valid[w_idx[W_PTR-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[W_PTR-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found && !flush && reset_n)
      w_grant[w_win] = 1'b1;
  end

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_tag  = w_tag  | req_tag[i*W_TAG +: W_TAG];
        w_data = w_data | req_data[i*W_DATA +: W_DATA];
      end
    end
  end

  assign w_ptr_nxt = (w_win == W_PTR'(N_REQ-1)) ?
                     '0 : w_win + 1'b1;

  // Idle and flushed cycles publish an all-zero bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      if (w_xfer)
        r_rr_ptr <= w_ptr_nxt;
      r_cdb_valid <= w_xfer;
      r_cdb_tag   <= w_tag;
      r_cdb_data  <= w_data;
      r_cdb_src   <= w_grant;
    end
  end

  assign cdb_valid      = r_cdb_valid;
  assign cdb_tag        = r_cdb_tag;
  assign cdb_data       = r_cdb_data;
  assign cdb_src_onehot = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector table plus async-reset and random-traffic checks
// for the CDB round-robin arbiter.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [3:0]   req_valid;
  logic [23:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [3:0]   cdb_src_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.N_REQ(4), .W_TAG(6), .W_DATA(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .cdb_src_onehot (cdb_src_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [3:0]  v;
    logic [5:0]  t;
    logic [31:0] d;
    logic [3:0]  er;
    logic        ev;
    logic [5:0]  et;
    logic [31:0] ed;
    logic [3:0]  es;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic [3:0] v,
                              input logic [5:0] t, input logic [31:0] d,
                              input logic [3:0] er, input int g);
    vec_t r;
    r.fl = fl; r.v = v; r.t = t; r.d = d; r.er = er;
    r.ev = (g >= 0);
    r.et = (g >= 0) ? t + 6'(g) : 6'h0;
    r.ed = (g >= 0) ? d + 32'(g) : 32'h0;
    r.es = er;
    return r;
  endfunction

  task automatic drive(input logic fl, input logic [3:0] v,
                       input logic [5:0] t, input logic [31:0] d);
    flush = fl;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*6 +: 6]   = t + 6'(i);
      req_data[i*32 +: 32] = d + 32'(i);
    end
  endtask

  // Independent round-robin reference.
  function automatic logic [3:0] mgrant(input int p, input logic [3:0] v);
    logic [3:0] g;
    g = 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (g == 4'b0 && v[(p + k) % 4]) g[(p + k) % 4] = 1'b1;
    end
    return g;
  endfunction

  logic [3:0]  rv;
  logic [5:0]  rt [4];
  logic [31:0] rd [4];
  int          wt [4];
  logic [5:0]  tag_ctr;
  int          mptr;
  logic [3:0]  eg;
  int          gi;
  logic        ok_ready, ok_cdb, ok_wait;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 4'b0, 6'h0, 32'h0);
    #12;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("reset_cdb_tag", 64'(cdb_tag), 64'h0);
    chk("reset_cdb_data", 64'(cdb_data), 64'h0);
    chk("reset_cdb_src", 64'(cdb_src_onehot), 64'h0);
    drive(1'b0, 4'b1111, 6'h0, 32'h0);
    #1;
    chk("reset_ready_low", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    vt.push_back(mk(0, 4'b0100, 6'h13, 32'hDEADBEED, 4'b0100, 2));
    vt.push_back(mk(0, 4'b1001, 6'h20, 32'h1000, 4'b1000, 3));
    vt.push_back(mk(0, 4'b1001, 6'h20, 32'h1000, 4'b0001, 0));
    vt.push_back(mk(0, 4'b1001, 6'h20, 32'h1000, 4'b1000, 3));
    vt.push_back(mk(1, 4'b1111, 6'h28, 32'h2000, 4'b0000, -1));
    vt.push_back(mk(0, 4'b0000, 6'h28, 32'h2000, 4'b0000, -1));
    for (int c = 0; c < 8; c++)
      vt.push_back(mk(0, 4'b1111, 6'h30, 32'hA0,
                      4'(1 << (c % 4)), c % 4));
    vt.push_back(mk(1, 4'b1111, 6'h30, 32'hA0, 4'b0000, -1));
    vt.push_back(mk(0, 4'b0110, 6'h08, 32'h5550, 4'b0010, 1));
    vt.push_back(mk(0, 4'b0110, 6'h08, 32'h5550, 4'b0100, 2));
    vt.push_back(mk(0, 4'b0010, 6'h08, 32'h5550, 4'b0010, 1));

    foreach (vt[j]) begin
      @(negedge clk);
      drive(vt[j].fl, vt[j].v, vt[j].t, vt[j].d);
      #1;
      chk($sformatf("v%0d_ready", j), 64'(req_ready), 64'(vt[j].er));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cdb_valid", j), 64'(cdb_valid), 64'(vt[j].ev));
      chk($sformatf("v%0d_cdb_tag", j), 64'(cdb_tag), 64'(vt[j].et));
      chk($sformatf("v%0d_cdb_data", j), 64'(cdb_data), 64'(vt[j].ed));
      chk($sformatf("v%0d_cdb_src", j), 64'(cdb_src_onehot), 64'(vt[j].es));
    end

    // Pointer is now 2; reset mid-cycle right after a transfer lands.
    @(negedge clk);
    drive(1'b0, 4'b1111, 6'h3A, 32'hCAFE0000);
    @(posedge clk);
    #1;
    chk("pre_reset_cdb_src", 64'(cdb_src_onehot), 64'h4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("async_cdb_tag", 64'(cdb_tag), 64'h0);
    chk("async_cdb_data", 64'(cdb_data), 64'h0);
    chk("async_cdb_src", 64'(cdb_src_onehot), 64'h0);
    chk("async_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post_reset_cdb_tag", 64'(cdb_tag), 64'h3A);
    chk("post_reset_cdb_src", 64'(cdb_src_onehot), 64'h1);

    // Random valid/hold traffic against the reference pointer.
    mptr = 1;
    tag_ctr = 6'h0;
    rv = 4'b0;
    for (int i = 0; i < 4; i++) begin
      rt[i] = '0; rd[i] = '0; wt[i] = 0;
    end
    ok_ready = 1'b1; ok_cdb = 1'b1; ok_wait = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && $urandom_range(1, 0) == 1) begin
          rv[i] = 1'b1;
          rt[i] = tag_ctr;
          rd[i] = $urandom;
          tag_ctr = tag_ctr + 6'h1;
        end
      end
      flush = 1'b0;
      req_valid = rv;
      for (int i = 0; i < 4; i++) begin
        req_tag[i*6 +: 6]    = rt[i];
        req_data[i*32 +: 32] = rd[i];
      end
      #1;
      eg = mgrant(mptr, rv);
      if (req_ready !== eg && ok_ready) begin
        ok_ready = 1'b0;
        $display("FAIL rand_ready cyc %0d: got %b expected %b",
                 cyc, req_ready, eg);
      end
      gi = -1;
      for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
      @(posedge clk);
      #1;
      if (gi >= 0) begin
        if ((cdb_valid !== 1'b1 || cdb_tag !== rt[gi] ||
             cdb_data !== rd[gi] || cdb_src_onehot !== eg) && ok_cdb) begin
          ok_cdb = 1'b0;
          $display("FAIL rand_cdb cyc %0d: got tag %h src %b expected tag %h src %b",
                   cyc, cdb_tag, cdb_src_onehot, rt[gi], eg);
        end
        mptr = (gi + 1) % 4;
      end else if (cdb_valid !== 1'b0 && ok_cdb) begin
        ok_cdb = 1'b0;
        $display("FAIL rand_cdb_idle cyc %0d: got valid %b expected 0",
                 cyc, cdb_valid);
      end
      for (int i = 0; i < 4; i++) begin
        if (rv[i] && !eg[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > 3 && ok_wait) begin
          ok_wait = 1'b0;
          $display("FAIL rand_wait req %0d: got %0d cycles expected <=3",
                   i, wt[i]);
        end
        if (eg[i]) rv[i] = 1'b0;
      end
    end
    chk("rand_ready_all", 64'(ok_ready), 64'h1);
    chk("rand_cdb_all", 64'(ok_cdb), 64'h1);
    chk("rand_wait_all", 64'(ok_wait), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
